id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline stage of the RV32 core; sits directly upstream of the ALU and drives its A, B and ALUOp inputs. Registers decoded instruction fields on each advance and resolves RAW hazards: EX/MEM and MEM/WB results are forwarded into the operands. On a load-use hazard, decode is stalled and a bubble is inserted. Also handles pipeline flush (taken branch/jump) and global hold (memory wait).

## Interface
- No parameters; XLEN fixed at 32, register index 5 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  32  instruction PC
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  32 each  register-file read data
- id_imm  in  32  sign-extended immediate
- id_alu_op  in  4  ALU operation code
- id_src_a_pc  in  1  A operand = PC instead of rs1
- id_src_b_imm  in  1  B operand = imm instead of rs2
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- exmem_rd  in  5;  exmem_reg_write  in  1;  exmem_result  in  32  EX/MEM forward source
- memwb_rd  in  5;  memwb_reg_write  in  1;  memwb_result  in  32  MEM/WB forward source
- flush  in  1  kill the instruction entering EX
- hold  in  1  global freeze (all stages frozen)
- stall_id  out  1  decode must hold its instruction this cycle
- ex_valid  out  1  EX slot is a real instruction
- alu_a, alu_b  out  32 each  ALU operands (post-forwarding)
- alu_op  out  4  to ALU
- ex_pc  out  32;  ex_rd  out  5;  ex_store_data  out  32 (forwarded rs2)
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  gated by ex_valid

## Operation
- The register update per rising edge follows this priority: flush > hold > load-use > advance.
  - flush: ex_valid←0; the other fields are don't-care.
  - hold: all registers keep their values.
  - load-use: ex_valid←0 (bubble); stall_id=1.
  - advance: all id_* fields are captured; ex_valid←id_valid.
- Load-use condition (combinational): ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall_id = hold | load-use. stall_id is not asserted while flush=1, because the decode instruction is also killed upstream.
- Forwarding is applied per registered source (rs1, rs2). The first matching rule wins:
  1. exmem_reg_write & exmem_rd≠0 & exmem_rd==rs selects exmem_result.
  2. Otherwise, memwb_reg_write & memwb_rd==rs & memwb_rd≠0 selects memwb_result.
  3. Otherwise, the registered register-file data is used.
- x0 is never forwarded.
- alu_a = src_a_pc ? ex_pc : fwd_rs1.
- alu_b = src_b_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2, always.
- ex_reg_write, ex_mem_read, ex_mem_write = registered bit & ex_valid. A bubble can therefore never write state.
- alu_op encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR
  - 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA
  - All other codes produce a zero result in the ALU. They are passed through unchanged.

## Timing
- Reset (async, on rst_n low): every register clears.
  - ex_valid=0, alu_op=0000, ex_rd=0, ex_pc=0, control bits=0.
  - Consequently, alu_a, alu_b and ex_store_data are 0 while no forward source matches.
- Latency: an id_* value presented at edge N appears on the ex_* / alu_* outputs after edge N, i.e. in cycle N+1.
- Forward muxing is combinational within the EX cycle and adds no latency.
- A load-use case costs exactly one bubble cycle. On the following edge the load is in MEM, and its data arrives via MEM/WB one cycle later.
- Reset deasserted mid-operation: the first edge after release behaves as advance from an empty pipe.
- Simultaneous flush and load-use: the flush wins, and stall_id=0.
- Simultaneous hold and flush: the flush still clears ex_valid.

## Structure
- Shared package core_pkg holds:
  - the ALU op localparams (ALU_ADD … ALU_SRA);
  - the forward-select encoding FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- One sub-module, fwd_unit: given rs, the registered data and both forward sources, it returns the 2-bit select and the 32-bit value. It is instantiated twice (rs1, rs2).
- Load-use detection and the pipeline registers live in id_ex_stage.

## Test plan
- **Reset:** rst_n=0 mid-stream → within the same cycle, ex_valid=0, alu_op=0000, ex_reg_write=0.
- **Plain advance:** id_rs1_data=5, id_rs2_data=7, alu_op=0000, no matches → next cycle alu_a=5, alu_b=7, ex_valid=1.
- **Forward priority:** rs1=3, exmem_rd=3 (result 0xAA), memwb_rd=3 (result 0xBB), both writes=1 → alu_a=0xAA. Repeat with exmem_reg_write=0 → alu_a=0xBB. Repeat with rs1=0 and all rd=0 → alu_a=rf data.
- **Load-use:** EX holds a load with rd=4; ID has add rs2=4, use_rs2=1 → stall_id=1 and one bubble (ex_valid=0, ex_reg_write=0). The next cycle the add enters with memwb_rd=4, memwb_result=0x1234 → alu_b=0x1234.
- **No false stall:** same case with use_rs2=0, or id_rs2=0 → stall_id=0.
- **Flush/hold:**
  - flush=1 with a valid ID → next cycle ex_valid=0.
  - hold=1 for 3 cycles → outputs unchanged and stall_id=1.
  - hold and flush together → ex_valid=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU op codes, forward-select
// encoding, the ID/EX pipeline payload and the forward-hit rule.
package core_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned FWD_W    = 2;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b0111;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEMWB = 2'b10;

  // Decoded instruction fields carried from ID into EX.
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic                src_a_pc;
    logic                src_b_imm;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
  } id_ex_t;

  // A later stage supplies rs only if it writes a non-x0 register equal to rs.
  function automatic logic fwd_hit(input logic we, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode fields, forward sources and flush/hold in;
// ALU operands, EX control and stall out. fwd_rs*_sel_c expose the chosen
// forward source per operand for observability.
interface id_ex_stage_if;
  import core_pkg::*;

  logic                id_valid;
  logic [XLEN-1:0]     id_pc;
  logic [REG_W-1:0]    id_rs1, id_rs2, id_rd;
  logic                id_use_rs1, id_use_rs2;
  logic [XLEN-1:0]     id_rs1_data, id_rs2_data, id_imm;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic                id_src_a_pc, id_src_b_imm;
  logic                id_reg_write, id_mem_read, id_mem_write;
  logic [REG_W-1:0]    exmem_rd;
  logic                exmem_reg_write;
  logic [XLEN-1:0]     exmem_result;
  logic [REG_W-1:0]    memwb_rd;
  logic                memwb_reg_write;
  logic [XLEN-1:0]     memwb_result;
  logic                flush, hold;

  logic                stall_id;
  logic                ex_valid;
  logic [XLEN-1:0]     alu_a, alu_b;
  logic [ALU_OP_W-1:0] alu_op;
  logic [XLEN-1:0]     ex_pc;
  logic [REG_W-1:0]    ex_rd;
  logic [XLEN-1:0]     ex_store_data;
  logic                ex_reg_write, ex_mem_read, ex_mem_write;
  logic [FWD_W-1:0]    fwd_rs1_sel_c, fwd_rs2_sel_c;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_src_a_pc, id_src_b_imm,
           id_reg_write, id_mem_read, id_mem_write,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result, flush, hold,
    input  stall_id, ex_valid, alu_a, alu_b, alu_op, ex_pc, ex_rd, ex_store_data,
           ex_reg_write, ex_mem_read, ex_mem_write, fwd_rs1_sel_c, fwd_rs2_sel_c
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rs1_data, id_rs2_data, id_imm, id_alu_op, id_src_a_pc, id_src_b_imm,
           id_reg_write, id_mem_read, id_mem_write,
           exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_result, flush, hold,
    output stall_id, ex_valid, alu_a, alu_b, alu_op, ex_pc, ex_rd, ex_store_data,
           ex_reg_write, ex_mem_read, ex_mem_write, fwd_rs1_sel_c, fwd_rs2_sel_c
  );
endinterface

// File: rtl/id_ex_stage_fwd.sv
// Operand forwarding for one source register.
// Ports: rs/rf_data (registered index and register-file data), EX/MEM and
// MEM/WB write-back sources in; fwd_sel_c (source select) and fwd_data_c out.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             exmem_reg_write,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_reg_write,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic [FWD_W-1:0] fwd_sel_c,
  output logic [XLEN-1:0]  fwd_data_c
);

  // Youngest producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    fwd_sel_c  = FWD_RF;
    fwd_data_c = rf_data;
    if (fwd_hit(exmem_reg_write, exmem_rd, rs)) begin
      fwd_sel_c  = FWD_EXMEM;
      fwd_data_c = exmem_result;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, rs)) begin
      fwd_sel_c  = FWD_MEMWB;
      fwd_data_c = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, hold and operand
// forwarding into the ALU.
// Ports: clk, rst_n (async active-low), bus (id_ex_stage_if.slave).
module id_ex_stage
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  id_ex_t          id_pkt;
  id_ex_t          ex_q, ex_d;
  logic            ex_valid_q, ex_valid_d;
  logic            load_use;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Pack the decode slot into the pipeline payload.
  always_comb begin
    id_pkt = '{pc:        bus.id_pc,
               rs1:       bus.id_rs1,
               rs2:       bus.id_rs2,
               rd:        bus.id_rd,
               rs1_data:  bus.id_rs1_data,
               rs2_data:  bus.id_rs2_data,
               imm:       bus.id_imm,
               alu_op:    bus.id_alu_op,
               src_a_pc:  bus.id_src_a_pc,
               src_b_imm: bus.id_src_b_imm,
               reg_write: bus.id_reg_write,
               mem_read:  bus.id_mem_read,
               mem_write: bus.id_mem_write};
  end

  // A load in EX cannot forward its data yet; a dependent decode must wait.
  always_comb begin
    load_use = ex_valid_q && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
               ((bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd)));
  end

  // Update priority: flush > hold > load-use bubble > advance.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (!bus.hold) begin
      if (load_use) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_d       = id_pkt;
        ex_valid_d = bus.id_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  fwd_unit u_fwd_rs1 (
    .rs              (ex_q.rs1),
    .rf_data         (ex_q.rs1_data),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_result    (bus.memwb_result),
    .fwd_sel_c       (bus.fwd_rs1_sel_c),
    .fwd_data_c      (fwd_rs1)
  );

  fwd_unit u_fwd_rs2 (
    .rs              (ex_q.rs2),
    .rf_data         (ex_q.rs2_data),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .exmem_result    (bus.exmem_result),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .memwb_result    (bus.memwb_result),
    .fwd_sel_c       (bus.fwd_rs2_sel_c),
    .fwd_data_c      (fwd_rs2)
  );

  // Decode is killed upstream on flush, so it is never told to stall then.
  always_comb begin
    bus.stall_id      = !bus.flush && (bus.hold || load_use);
    bus.ex_valid      = ex_valid_q;
    bus.alu_a         = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
    bus.alu_b         = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
    bus.alu_op        = ex_q.alu_op;
    bus.ex_pc         = ex_q.pc;
    bus.ex_rd         = ex_q.rd;
    bus.ex_store_data = fwd_rs2;
    bus.ex_reg_write  = ex_q.reg_write && ex_valid_q;
    bus.ex_mem_read   = ex_q.mem_read  && ex_valid_q;
    bus.ex_mem_write  = ex_q.mem_write && ex_valid_q;
  end

endmodule
